// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control path: FSM states,
// opcodes, ALUop codes and datapath mux selects.
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_START, S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXEC_R,
    S_EXEC_I, S_ALUWB, S_BRANCH, S_JAL, S_JALR, S_LUI, S_AUIPC, S_TRAP
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [2:0] ALUOP_R    = 3'b000;
  localparam logic [2:0] ALUOP_I    = 3'b001;
  localparam logic [2:0] ALUOP_ADD  = 3'b010;
  localparam logic [2:0] ALUOP_BR   = 3'b100;
  localparam logic [2:0] ALUOP_JALR = 3'b101;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  localparam logic [1:0] SRCB_RS2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_RDATA  = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;

endpackage

// File: rtl/multicycle_ctrl_branch_cond.sv
// Branch direction from funct3 and the datapath flags; lt already carries
// signed or unsigned meaning depending on the branch flavour.
module branch_cond (
  input  logic [2:0] funct3,
  input  logic       zero,
  input  logic       lt,
  output logic       taken
);

  always_comb begin
    taken = 1'b0;
    case (funct3)
      3'b000:          taken = zero;
      3'b001:          taken = ~zero;
      3'b100, 3'b110:  taken = lt;
      3'b101, 3'b111:  taken = ~lt;
      default:         taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multi-cycle RV32I core: sequences memory, ALU
// and write strobes, and counts retired instructions.
module multicycle_ctrl
  import riscv_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic        zero,
  input  logic        lt,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        adr_src,
  output logic        mem_write,
  output logic        ir_write,
  output logic        pc_write,
  output logic        reg_write,
  output logic [1:0]  alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [2:0]  alu_op,
  output logic [1:0]  result_src,
  output logic        halted,
  output logic [31:0] instret
);

  state_t      state_q, state_d;
  logic [31:0] instret_q;
  logic        taken;

  branch_cond u_branch_cond (
    .funct3 (funct3),
    .zero   (zero),
    .lt     (lt),
    .taken  (taken)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_START;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      // Retirement is the return to FETCH from any instruction step.
      if (state_d == S_FETCH && state_q != S_START && state_q != S_FETCH)
        instret_q <= instret_q + 32'd1;
    end
  end

  assign instret = instret_q;

  always_comb begin
    state_d    = state_q;
    mem_req    = 1'b0;
    adr_src    = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_RS2;
    alu_op     = ALUOP_R;
    result_src = RES_ALUOUT;
    halted     = 1'b0;
    case (state_q)
      S_START: state_d = S_FETCH;
      S_FETCH: begin
        mem_req    = 1'b1;
        alu_src_b  = SRCB_FOUR;
        alu_op     = ALUOP_ADD;
        result_src = RES_ALURES;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        alu_op    = ALUOP_ADD;
        case (opcode)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_R:              state_d = S_EXEC_R;
          OP_I:              state_d = S_EXEC_I;
          OP_BRANCH:         state_d = (funct3[2:1] == 2'b01) ? S_TRAP : S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          OP_JALR:           state_d = S_JALR;
          OP_LUI:            state_d = S_LUI;
          OP_AUIPC:          state_d = S_AUIPC;
          default:           state_d = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALUOP_ADD;
        state_d   = (opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = RES_RDATA;
        reg_write  = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWRITE: begin
        mem_req   = 1'b1;
        adr_src   = 1'b1;
        mem_write = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end
      S_EXEC_R: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_RS2;
        alu_op    = ALUOP_R;
        state_d   = S_ALUWB;
      end
      S_EXEC_I: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALUOP_I;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        result_src = RES_ALUOUT;
        reg_write  = 1'b1;
        state_d    = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a  = SRCA_RS1;
        alu_src_b  = SRCB_RS2;
        alu_op     = ALUOP_BR;
        result_src = RES_ALUOUT;
        pc_write   = taken;
        state_d    = S_FETCH;
      end
      S_JAL: begin
        // Target in ALUOut goes to PC while OldPC+4 is computed for the link.
        alu_src_a  = SRCA_OLDPC;
        alu_src_b  = SRCB_FOUR;
        alu_op     = ALUOP_ADD;
        result_src = RES_ALUOUT;
        pc_write   = 1'b1;
        state_d    = S_ALUWB;
      end
      S_JALR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALUOP_JALR;
        state_d   = S_JAL;
      end
      S_LUI: begin
        alu_src_a = SRCA_ZERO;
        alu_src_b = SRCB_IMM;
        alu_op    = ALUOP_ADD;
        state_d   = S_ALUWB;
      end
      S_AUIPC: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        alu_op    = ALUOP_ADD;
        state_d   = S_ALUWB;
      end
      S_TRAP: halted = 1'b1;
      default: state_d = S_TRAP;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: acts as IR and memory, predicts per-instruction
// latency, strobe counts and handshake behaviour from instruction class.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  opcode = 7'h00;
  logic [2:0]  funct3 = 3'h0;
  logic        zero = 1'b0, lt = 1'b0, mem_ready = 1'b0;
  logic        mem_req, adr_src, mem_write, ir_write, pc_write, reg_write, halted;
  logic [1:0]  alu_src_a, alu_src_b, result_src;
  logic [2:0]  alu_op;
  logic [31:0] instret;

  int checks = 0;
  int errors = 0;
  int last_cycles;

  logic rec_req [64];
  logic rec_adr [64];
  logic rec_rw  [64];
  logic rec_pw  [64];
  logic [2:0] rec_aluop [64];
  logic [1:0] rec_rs [64];

  // class: 0 load 1 store 2 R 3 I 4 branch 5 jal 6 jalr 7 lui 8 auipc
  logic [6:0] op_tab [9] = '{7'h03, 7'h23, 7'h33, 7'h13, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};
  int         base_tab [9] = '{5, 4, 4, 4, 3, 4, 5, 4, 4};
  logic [2:0] exop_tab [9] = '{3'b010, 3'b010, 3'b000, 3'b001, 3'b100, 3'b010, 3'b101, 3'b010, 3'b010};
  logic [2:0] br_f3 [6] = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b110, 3'b111};

  multicycle_ctrl dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .zero(zero), .lt(lt),
    .mem_ready(mem_ready), .mem_req(mem_req), .adr_src(adr_src), .mem_write(mem_write),
    .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .result_src(result_src), .halted(halted), .instret(instret)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] all_outs();
    return {mem_req, adr_src, mem_write, ir_write, pc_write, reg_write,
            alu_src_a, alu_src_b, alu_op, result_src, halted};
  endfunction

  function automatic bit br_taken(input logic [2:0] f3, input logic z, input logic l);
    case (f3)
      3'b000: return z;
      3'b001: return !z;
      3'b100, 3'b110: return l;
      default: return !l;
    endcase
  endfunction

  // Runs one instruction starting in FETCH; fw/mw are wait cycles for the
  // fetch and the data access.
  task automatic run_instr(input int cls, input logic [2:0] f3, input logic z,
                           input logic l, input int fw, input int mw);
    logic [31:0] start;
    int cyc, n_rw, n_pw, n_req, n_mw, n_ir, wl, stab_err, ls;
    bit done, in_acc;
    logic acc_adr, acc_mw;
    logic [1:0] rs_at_rw;
    opcode = op_tab[cls]; funct3 = f3; zero = z; lt = l;
    start = instret; done = 0; cyc = 0; in_acc = 0; wl = 0; stab_err = 0;
    n_rw = 0; n_pw = 0; n_req = 0; n_mw = 0; n_ir = 0;
    acc_adr = 1'b0; acc_mw = 1'b0; rs_at_rw = 2'b11;
    ls = (cls <= 1) ? 1 : 0;
    while (!done && cyc < 64) begin
      @(negedge clk);
      if (mem_req) begin
        if (!in_acc) begin
          in_acc = 1; wl = adr_src ? mw : fw; acc_adr = adr_src; acc_mw = mem_write;
        end
        mem_ready = (wl == 0);
      end else begin
        mem_ready = 1'($urandom_range(0, 1));
      end
      #1;
      if (mem_req && (adr_src !== acc_adr || mem_write !== acc_mw)) stab_err++;
      rec_req[cyc] = mem_req; rec_adr[cyc] = adr_src; rec_rw[cyc] = reg_write;
      rec_pw[cyc] = pc_write; rec_aluop[cyc] = alu_op; rec_rs[cyc] = result_src;
      if (reg_write) begin n_rw++; rs_at_rw = result_src; end
      if (pc_write) n_pw++;
      if (mem_req) n_req++;
      if (mem_write) n_mw++;
      if (ir_write) n_ir++;
      if (mem_req) begin
        if (mem_ready) in_acc = 0; else wl--;
      end
      @(posedge clk); #1;
      cyc++;
      if (instret !== start) done = 1;
    end
    last_cycles = cyc;
    chk("retire_timeout", 32'(done), 32'd1);
    chk("cycles", cyc, base_tab[cls] + fw + (ls ? mw : 0));
    chk("instret_step", instret, start + 32'd1);
    chk("reg_write_cnt", n_rw, (cls == 1 || cls == 4) ? 0 : 1);
    chk("pc_write_cnt", n_pw, 1 + ((cls == 5 || cls == 6) ? 1 : 0)
                             + ((cls == 4 && br_taken(f3, z, l)) ? 1 : 0));
    chk("ir_write_cnt", n_ir, 1);
    chk("mem_req_cycles", n_req, fw + 1 + (ls ? mw + 1 : 0));
    chk("mem_write_cycles", n_mw, (cls == 1) ? mw + 1 : 0);
    chk("mem_stable", stab_err, 0);
    chk("exec_alu_op", rec_aluop[fw + 2], exop_tab[cls]);
    chk("decode_alu_op", rec_aluop[fw + 1], 3'b010);
    if (n_rw == 1) chk("wb_result_src", rs_at_rw, (cls == 0) ? 2'b01 : 2'b00);
  endtask

  task automatic do_reset();
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("rst_outs_zero", all_outs(), 16'h0);
    chk("rst_instret", instret, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("start_no_req", mem_req, 1'b0);
    @(posedge clk); #1;
    chk("first_req", mem_req, 1'b1);
  endtask

  task automatic run_trap(input logic [6:0] op, input logic [2:0] f3);
    logic [31:0] start;
    int bad_req, bad_halt, bad_strobe;
    opcode = op; funct3 = f3; start = instret;
    bad_req = 0; bad_halt = 0; bad_strobe = 0;
    for (int c = 0; c < 103; c++) begin
      @(negedge clk);
      mem_ready = (c == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      zero = 1'($urandom_range(0, 1)); lt = 1'($urandom_range(0, 1));
      #1;
      if (c >= 2) begin
        if (mem_req !== 1'b0) bad_req++;
        if (halted !== 1'b1) bad_halt++;
        if ({ir_write, pc_write, reg_write, mem_write} !== 4'b0) bad_strobe++;
      end
      @(posedge clk); #1;
    end
    chk("trap_mem_req", bad_req, 0);
    chk("trap_halted", bad_halt, 0);
    chk("trap_strobes", bad_strobe, 0);
    chk("trap_instret", instret, start);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    do_reset();

    run_instr(3, 3'b000, 1'b0, 1'b0, 0, 0);
    chk("addi_cycles", last_cycles, 4);
    chk("addi_exec_i", rec_aluop[2], 3'b001);
    chk("addi_aluwb", rec_rw[3], 1'b1);
    chk("addi_instret", instret, 32'd1);

    run_instr(0, 3'b010, 1'b0, 1'b0, 0, 2);
    for (int i = 3; i <= 5; i++) begin
      chk("lw_req_held", rec_req[i], 1'b1);
      chk("lw_adr_src", rec_adr[i], 1'b1);
    end
    chk("lw_rw_cycle7", rec_rw[6], 1'b1);
    chk("lw_rs_cycle7", rec_rs[6], 2'b01);

    run_instr(4, 3'b000, 1'b1, 1'b0, 0, 0);
    chk("beq_taken", rec_pw[2], 1'b1);
    run_instr(4, 3'b000, 1'b0, 1'b0, 0, 0);
    chk("beq_not_taken", rec_pw[2], 1'b0);
    run_instr(4, 3'b111, 1'b0, 1'b0, 0, 0);
    chk("bgeu_taken", rec_pw[2], 1'b1);

    run_instr(6, 3'b000, 1'b0, 1'b0, 0, 0);
    chk("jalr_aluop", rec_aluop[2], 3'b101);
    chk("jalr_jal_pw", rec_pw[3], 1'b1);
    chk("jalr_aluwb", rec_rw[4], 1'b1);

    for (int n = 0; n < 40; n++) begin
      int cls;
      logic [2:0] f3;
      cls = $urandom_range(0, 8);
      f3 = (cls == 4) ? br_f3[$urandom_range(0, 5)] : 3'($urandom_range(0, 7));
      run_instr(cls, f3, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                $urandom_range(0, 3), $urandom_range(0, 3));
    end

    force dut.instret_q = 32'hFFFF_FFFF;
    #1;
    release dut.instret_q;
    run_instr(2, 3'b000, 1'b0, 1'b0, 0, 0);
    chk("instret_wrap", instret, 32'h0);

    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    chk("fetch_wait_req", mem_req, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midreset_req", mem_req, 1'b0);
    chk("midreset_instret", instret, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("restart_start", mem_req, 1'b0);
    @(posedge clk); #1;
    chk("restart_fetch", mem_req, 1'b1);
    run_instr(7, 3'b000, 1'b0, 1'b0, 1, 0);
    chk("restart_instret", instret, 32'd1);

    run_trap(7'h7F, 3'b000);
    do_reset();
    run_trap(7'h63, 3'b010);
    do_reset();
    run_instr(1, 3'b010, 1'b0, 1'b0, 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Main control FSM for the multi-cycle RV32I core. Sequences one shared ALU, one unified instruction/data memory port and the PC/IR/register-file write strobes through fetch, decode, execute, memory and writeback steps. Emits the 3-bit ALUop consumed by the ALU decoder and resolves branch direction from datapath flags. Counts retired instructions and halts on illegal opcodes.

## Interface
- No parameters; all encodings are fixed constants.
- clk  in  1  core clock
- rst_n  in  1  asynchronous, active-low reset
- opcode  in  7  instr[6:0] from the IR
- funct3  in  3  instr[14:12] from the IR
- zero  in  1  ALU result equals zero
- lt  in  1  comparison flag from the datapath: signed for blt/bge, unsigned for bltu/bgeu
- mem_ready  in  1  memory completes the current access this cycle
- mem_req  out  1  memory access request
- adr_src  out  1  0 selects PC, 1 selects ALUOut as the memory address
- mem_write  out  1  request is a store
- ir_write  out  1  load IR and OldPC
- pc_write  out  1  load PC from the result mux
- reg_write  out  1  register-file write enable
- alu_src_a  out  2  00 PC, 01 OldPC, 10 rs1 register, 11 zero
- alu_src_b  out  2  00 rs2 register, 01 immediate, 10 constant 4
- alu_op  out  3  000 R-type, 001 I-type, 010 add, 100 branch, 101 jalr
- result_src  out  2  00 ALUOut, 01 read data, 10 ALUResult
- halted  out  1  FSM is in TRAP
- instret  out  32  retired-instruction counter

## Operation
- States: START, FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXEC_R, EXEC_I, ALUWB, BRANCH, JAL, JALR, LUI, AUIPC, TRAP. Outputs are decoded from the state, plus mem_ready and the taken signal.
- Every output not listed for a state is 0.
- START: all outputs 0; goes to FETCH.
- FETCH: mem_req=1, adr_src=0, a=00, b=10, alu_op=010, result_src=10. ir_write and pc_write are asserted only when mem_ready=1; the FSM then moves to DECODE. Otherwise it stays in FETCH.
- DECODE: a=01, b=01, alu_op=010, so the branch/jal target goes to ALUOut. Next state by opcode:
  - 0000011 and 0100011 go to MEMADR.
  - 0110011 goes to EXEC_R.
  - 0010011 goes to EXEC_I.
  - 1100011 goes to BRANCH, except funct3 010/011, which go to TRAP.
  - 1101111 goes to JAL.
  - 1100111 goes to JALR.
  - 0110111 goes to LUI.
  - 0010111 goes to AUIPC.
  - Any other opcode goes to TRAP.
- MEMADR: a=10, b=01, alu_op=010. Goes to MEMREAD on a load, MEMWRITE on a store.
- MEMREAD: mem_req=1, adr_src=1. Waits for mem_ready, then goes to MEMWB.
- MEMWB: result_src=01, reg_write=1; goes to FETCH.
- MEMWRITE: mem_req=1, adr_src=1, mem_write=1. Waits for mem_ready, then goes to FETCH.
- EXEC_R: a=10, b=00, alu_op=000; goes to ALUWB.
- EXEC_I: a=10, b=01, alu_op=001; goes to ALUWB.
- ALUWB: result_src=00, reg_write=1; goes to FETCH.
- BRANCH: a=10, b=00, alu_op=100, result_src=00, pc_write=taken; goes to FETCH.
  - taken by funct3: 000 zero, 001 !zero, 100 lt, 101 !lt, 110 lt, 111 !lt.
- JAL: a=01, b=10, alu_op=010, result_src=00, pc_write=1. ALUOut (the target) goes to PC while OldPC+4 goes to ALUOut. Then goes to ALUWB.
- JALR: a=10, b=01, alu_op=101; the target goes to ALUOut. Then goes to JAL.
- LUI: a=11, b=01, alu_op=010; goes to ALUWB.
- AUIPC: a=01, b=01, alu_op=010; goes to ALUWB.
- TRAP: halted=1, all strobes 0; stays in TRAP until reset.
- instret increments by 1 on every transition into FETCH from any state other than START or FETCH. It wraps from 0xFFFFFFFF to 0. It never increments in TRAP.

## Timing
- Reset (async assert, sync release): state=START, instret=0. All outputs are 0 while rst_n=0, including mem_req.
- First mem_req is asserted 1 cycle after rst_n releases.
- Cycle counts with zero memory wait:
  - load: 5
  - store: 4
  - R/I/LUI/AUIPC: 4
  - branch: 3
  - jal: 4
  - jalr: 5
- Each mem_ready=0 cycle in FETCH, MEMREAD or MEMWRITE adds one cycle.
- Memory handshake:
  - mem_req stays high until mem_ready is sampled high.
  - adr_src and mem_write stay stable while mem_req is high.
  - mem_ready is ignored when mem_req=0.
- Reset asserted mid-access: mem_req drops immediately, the access is abandoned, instret clears.
- Flag inputs (zero, lt) are sampled only in BRANCH, in the same cycle.

## Structure
- Package riscv_ctrl_pkg holds:
  - state_t (enum, 4 bits)
  - opcode constants (OP_LOAD, OP_STORE, OP_R, OP_I, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC)
  - ALUop constants (ALUOP_R=000, ALUOP_I=001, ALUOP_ADD=010, ALUOP_BR=100, ALUOP_JALR=101)
  - SrcA/SrcB/ResultSrc select constants
- One combinational sub-module, branch_cond: inputs funct3, zero, lt; output taken.

## Test plan
- Reset release, mem_ready tied to 1, IR=addi (0x00500093): FETCH, DECODE, EXEC_I (alu_op=001), ALUWB (reg_write=1); instret=1 after 4 cycles.
- Load lw (0x0000A103) with mem_ready low for 2 cycles in MEMREAD: mem_req held and adr_src=1 throughout; reg_write with result_src=01 on cycle 7; instret=1.
- beq with zero=1 and then with zero=0: pc_write=1 in BRANCH for the first, pc_write=0 for the second; bgeu with lt=0 gives pc_write=1.
- jalr (0x000080E7): path is DECODE, JALR (alu_op=101), JAL (pc_write=1), ALUWB (reg_write=1) — 5 cycles total.
- Opcode 0x7F, or a branch with funct3=010: TRAP, halted=1, mem_req stays 0 for 100 cycles, instret frozen.
- rst_n pulled low during a FETCH wait: mem_req=0 in the same cycle, instret=0; restart through START. Preload instret=0xFFFFFFFF by force and retire one instruction: instret=0.
